strhw_adder_512: RTL and testbench
==================================

Name: strhw_adder_512

Overview:
- Sequential 512-bit modular adder (sum mod 2^512) for the Streebog hash core.
- Used by the stage controller to update N (N + 512 or N + block length) and Sigma (Sigma + message block).
- Operation is started by a one-cycle trigger pulse and completes over several cycles, adding one chunk per clock with a ripple carry between chunks.
- Completion is signalled by a ready level.

Parameters:
- CHUNK_W, 64: bits added per clock. Legal values are 8, 16, 32, 64, 128, 256 and 512 (must divide 512). NCHUNK = 512/CHUNK_W.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- trg_i  input  1  start request, sampled on the rising edge.
- a_i  input  512  operand A, unsigned, bit 0 = LSB.
- b_i  input  512  operand B, unsigned, bit 0 = LSB.
- result_o  output  512  registered (A+B) mod 2^512; valid only while ready_o=1.
- ready_o  output  1  high when result_o holds the completed sum of the last started operation.

Behaviour:
- Reset (rst_i=0, asynchronous assert, synchronous release):
  - result_o=0, ready_o=0, state IDLE, chunk counter=0, carry=0.
  - Captured operand registers are cleared.
  - Reset mid-operation aborts the operation; no completion follows.
- States: IDLE and BUSY.
- IDLE:
  - On an edge with trg_i=1: capture a_i and b_i into internal registers, clear carry and counter, go to BUSY.
  - On that same edge, ready_o goes to 0. This is mandatory, so a stale ready is never seen in the cycle after trigger.
  - With trg_i=0: hold everything.
- BUSY, each edge processes chunk k = counter:
  - {carry, result_o[k*CHUNK_W +: CHUNK_W]} = A_chunk + B_chunk + carry.
  - counter increments.
  - On the edge that processes chunk NCHUNK-1: discard the final carry (mod 2^512), set ready_o=1, return to IDLE.
- Latency: ready_o rises exactly NCHUNK edges after the edge that sampled trg_i=1. This is 8 cycles at default; 1 cycle for CHUNK_W=512.
- trg_i is ignored while BUSY. Operands are taken only from the capture edge; a_i and b_i may change freely afterwards.
- A trigger in the IDLE cycle right after completion starts a new operation immediately (back-to-back).
- trg_i held high continuously restarts the operation every NCHUNK+1 cycles.
- Held trigger timing: ready_o is high for one cycle only, because it drops on the next capture edge.
- result_o:
  - Updated chunk by chunk while BUSY, so intermediate values are partial.
  - After completion it holds the value until the next capture edge.
  - It is not cleared by a new trigger; untouched upper chunks keep old bits until overwritten.
- ready_o: a level, not a pulse. It stays high in IDLE until the next trigger is sampled.
- No overflow flag; wrap-around is silent.

Test Plan:
- Reset then idle:
  - Check result_o=0 and ready_o=0 for 20 cycles with trg_i=0.
  - Assert rst_i=0 asynchronously mid-cycle; outputs clear before the next edge.
- Basic add: a=0, b=512 (N update), one-cycle trg pulse.
  - ready_o=0 on the cycle after trigger.
  - ready_o=1 exactly NCHUNK cycles after the trigger edge, with result_o=0x200.
- Carry propagation and wrap-around:
  - a=2^512-1, b=1 → result_o=0, ready=1.
  - a=2^64-1, b=1 → result_o=2^64, which checks the carry across the chunk boundary.
- Stale-ready protection:
  - Complete one add (ready=1), then pulse trg with a=5, b=7.
  - ready_o must read 0 on the next cycle and only rise with result_o=12.
- Operand capture and ignored trigger:
  - Change a_i/b_i and pulse trg_i during BUSY.
  - Result equals the sum of the originally captured operands; exactly one completion occurs.
  - Back-to-back trigger right after ready yields the correct second sum.
- Random regression: 1000 random 512-bit pairs at CHUNK_W=64 and CHUNK_W=512, compared against a reference sum mod 2^512, with the latency check on every pair.

Source files
------------

// File: rtl/strhw_adder_512.sv
// -----------------------------------------------------------------------------
// strhw_adder_512
//   Sequential 512-bit modular adder (sum mod 2^512) for the Streebog core.
//   Used to update N (N + 512 / N + block length) and Sigma (Sigma + block).
//   A one-cycle trigger captures both operands. The adder then processes one
//   CHUNK_W-bit chunk per clock, least significant chunk first, and ripples
//   the carry from one chunk to the next. ready_o is a level. It rises
//   NCHUNK edges after the capture edge and stays high until the next capture.
//
// Parameters
//   CHUNK_W   bits added per clock: 8,16,32,64,128,256 or 512
//
// Ports
//   clk_i     clock, rising edge
//   rst_i     asynchronous active-low reset
//   trg_i     start request, honoured only while idle
//   a_i, b_i  512-bit unsigned operands, sampled on the capture edge
//   result_o  registered (a+b) mod 2^512, valid while ready_o=1
//   ready_o   result_o holds the completed sum of the last started operation
// -----------------------------------------------------------------------------
module strhw_adder_512 #(
  parameter int unsigned CHUNK_W = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         trg_i,
  input  logic [511:0] a_i,
  input  logic [511:0] b_i,
  output logic [511:0] result_o,
  output logic         ready_o
);

  localparam int unsigned NCHUNK = 512 / CHUNK_W;
  localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCHUNK - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic               carry_q,  carry_d;
  logic [511:0]       a_q,      a_d;
  logic [511:0]       b_q,      b_d;
  logic [511:0]       result_q, result_d;
  logic               ready_q,  ready_d;

  logic [CHUNK_W-1:0] a_chunk;
  logic [CHUNK_W-1:0] b_chunk;
  logic [CHUNK_W:0]   sum_w;

  // Adder for the current chunk. The top bit of sum_w is the carry into the
  // next chunk.
  always_comb begin
    a_chunk = a_q[cnt_q * CHUNK_W +: CHUNK_W];
    b_chunk = b_q[cnt_q * CHUNK_W +: CHUNK_W];
    sum_w   = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK_W{1'b0}}, carry_q};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    ready_d  = ready_q;

    unique case (state_q)
      IDLE: begin
        if (trg_i) begin
          a_d     = a_i;
          b_d     = b_i;
          carry_d = 1'b0;
          cnt_d   = '0;
          // Drop ready on the capture edge. A stale result is then never
          // flagged in the cycle after the trigger.
          ready_d = 1'b0;
          state_d = BUSY;
        end
      end

      BUSY: begin
        result_d[cnt_q * CHUNK_W +: CHUNK_W] = sum_w[CHUNK_W-1:0];
        carry_d = sum_w[CHUNK_W];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_CHUNK) begin
          // The final carry is discarded, which gives the mod 2^512 wrap.
          carry_d = 1'b0;
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_strhw_adder_512.sv
// -----------------------------------------------------------------------------
// tb_strhw_adder_512
//   Self-checking bench for strhw_adder_512. Instance 0 uses CHUNK_W=64 and
//   instance 1 uses CHUNK_W=512. The expected sum is plain 512-bit addition,
//   which wraps mod 2^512 by width. The expected latency is 512/CHUNK_W.
// -----------------------------------------------------------------------------
module tb_strhw_adder_512;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         trg [2];
  logic [511:0] a   [2];
  logic [511:0] b   [2];
  logic [511:0] res [2];
  logic         rdy [2];

  int unsigned nch [2] = '{8, 1};

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  strhw_adder_512 #(.CHUNK_W(64)) u_dut64 (
    .clk_i    (clk),
    .rst_i    (rst_n),
    .trg_i    (trg[0]),
    .a_i      (a[0]),
    .b_i      (b[0]),
    .result_o (res[0]),
    .ready_o  (rdy[0])
  );

  strhw_adder_512 #(.CHUNK_W(512)) u_dut512 (
    .clk_i    (clk),
    .rst_i    (rst_n),
    .trg_i    (trg[1]),
    .a_i      (a[1]),
    .b_i      (b[1]),
    .result_o (res[1]),
    .ready_o  (rdy[1])
  );

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Pulse the trigger for one cycle and check that ready drops after the
  // capture edge. Then check the latency and the sum. Returns at
  // posedge+1 of the cycle in which ready is first seen high.
  task automatic do_op(input int sel, input logic [511:0] va, input logic [511:0] vb,
                       input string tag);
    int unsigned n;
    logic [511:0] exp;
    exp = va + vb;
    a[sel]   = va;
    b[sel]   = vb;
    trg[sel] = 1'b1;
    step();
    trg[sel] = 1'b0;
    check({tag, "_rdy_low"}, {511'd0, rdy[sel]}, 512'd0);
    n = 0;
    while (!rdy[sel] && n < 40) begin
      step();
      n++;
    end
    check({tag, "_latency"}, 512'(n), 512'(nch[sel]));
    check({tag, "_sum"}, res[sel], exp);
  endtask

  initial begin
    logic [511:0] ones;
    logic [511:0] ra, rb, hold_res;
    int unsigned  n;
    bit           seen;

    ones = '1;
    for (int s = 0; s < 2; s++) begin
      trg[s] = 1'b0;
      a[s]   = '0;
      b[s]   = '0;
    end

    // Reset, then stay idle.
    repeat (3) step();
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      for (int s = 0; s < 2; s++) begin
        check("idle_res", res[s], 512'd0);
        check("idle_rdy", {511'd0, rdy[s]}, 512'd0);
      end
    end

    for (int s = 0; s < 2; s++) begin
      do_op(s, 512'd0, 512'd512, "basic");
      check("basic_const", res[s], 512'h200);
      do_op(s, ones, 512'd1, "wrap");
      do_op(s, {448'd0, 64'hFFFF_FFFF_FFFF_FFFF}, 512'd1, "carry64");
      check("carry64_const", res[s], 512'd1 << 64);
      // ready is high at this point. The next op checks for a stale ready.
      do_op(s, 512'd5, 512'd7, "stale");
      check("stale_const", res[s], 512'd12);
    end

    // Operands change and the trigger is pulsed while the adder is busy.
    ra = rand512();
    rb = rand512();
    a[0] = ra; b[0] = rb; trg[0] = 1'b1;
    step();
    trg[0] = 1'b0;
    step(); step();
    a[0] = rand512(); b[0] = rand512(); trg[0] = 1'b1;
    step();
    trg[0] = 1'b0;
    n = 3;
    while (!rdy[0] && n < 40) begin
      step();
      n++;
    end
    check("busy_trg_latency", 512'(n), 512'(nch[0]));
    check("busy_trg_sum", res[0], ra + rb);
    hold_res = res[0];
    repeat (nch[0] + 2) step();
    check("busy_trg_hold_rdy", {511'd0, rdy[0]}, 512'd1);
    check("busy_trg_hold_res", res[0], hold_res);

    // Start a second operation in the idle cycle right after completion.
    do_op(0, 512'd100, 512'd23, "b2b_first");
    do_op(0, ones, ones, "b2b_second");
    do_op(1, 512'd100, 512'd23, "b2b_first1");
    do_op(1, ones, ones, "b2b_second1");

    // With the trigger held high, ready is high for exactly one cycle per
    // period.
    ra = rand512(); rb = rand512();
    a[0] = ra; b[0] = rb; trg[0] = 1'b1;
    step();
    n = 0;
    while (!rdy[0] && n < 40) begin
      step();
      n++;
    end
    check("held_lat1", 512'(n), 512'(nch[0]));
    check("held_sum1", res[0], ra + rb);
    step();
    check("held_rdy_drop", {511'd0, rdy[0]}, 512'd0);
    n = 0;
    while (!rdy[0] && n < 40) begin
      step();
      n++;
    end
    check("held_lat2", 512'(n), 512'(nch[0]));
    trg[0] = 1'b0;
    step();

    // Assert reset asynchronously in the middle of an operation.
    a[0] = ones; b[0] = ones; trg[0] = 1'b1;
    step();
    trg[0] = 1'b0;
    step(); step();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_res", res[0], 512'd0);
    check("async_rst_rdy", {511'd0, rdy[0]}, 512'd0);
    step();
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      step();
      if (rdy[0]) seen = 1'b1;
    end
    check("abort_no_ready", {511'd0, seen}, 512'd0);

    // Random pairs. Every fourth pair is biased toward long carry chains.
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 1000; i++) begin
        ra = rand512();
        if (i % 4 == 0) rb = ~ra + 512'($urandom_range(0, 3));
        else            rb = rand512();
        do_op(s, ra, rb, "rand");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Stop the run if the stimulus never reaches the summary.
  initial begin
    #2_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
